// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges NUM_PORTS AXI-Stream requesters onto a single UART TX stream,
// optionally prefixing each granted packet with a header beat that identifies the source port.
//
// state  | meaning
// IDLE   | no owner; pick next requester round-robin from last_port+1
// HDR    | present HDR_BASE | port index until the transmitter accepts it
// DATA   | pass granted port through until tlast or the beat limit
module uart_tx_arbiter #(
    parameter int          NUM_PORTS = 4,
    parameter bit          ID_PREFIX = 1'b1,
    parameter logic [15:0] HDR_BASE  = 16'h0100,
    parameter int          MAX_BEATS = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_PORTS*16-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]    s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]    s_axis_tlast,
    output logic [NUM_PORTS-1:0]    s_axis_tready,
    output logic [15:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [NUM_PORTS-1:0]    grant,
    output logic                    busy
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] last_port_q, last_port_d;
    logic [15:0]      beat_cnt_q, beat_cnt_d;
    logic [16:0]      beat_cnt_inc;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             g_valid, g_last, beat_acc;
    logic [15:0]      g_data;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = IDX_W'((int'(last_port_q) + off) % NUM_PORTS);
            if (!pick_found && s_axis_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_idx_q == IDX_W'(i)) begin
                g_valid = s_axis_tvalid[i];
                g_last  = s_axis_tlast[i];
                g_data  = s_axis_tdata[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_idx_d     = gnt_idx_q;
        last_port_d   = last_port_q;
        beat_cnt_d    = beat_cnt_q;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;
        beat_acc      = 1'b0;
        beat_cnt_inc  = {1'b0, beat_cnt_q} + 17'd1;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_idx_d  = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ID_PREFIX ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = HDR_BASE | 16'(gnt_idx_q);
                if (m_axis_tready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                m_axis_tvalid            = g_valid;
                m_axis_tdata             = g_data;
                s_axis_tready[gnt_idx_q] = m_axis_tready;
                beat_acc                 = g_valid && m_axis_tready;
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_inc[15:0];
                    // Forced release lets a long packet yield; its tail re-arbitrates later.
                    if (g_last || beat_cnt_inc == 17'(MAX_BEATS)) begin
                        state_d     = S_IDLE;
                        last_port_d = gnt_idx_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        grant = '0;
        if (busy) begin
            grant[gnt_idx_q] = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            gnt_idx_q   <= '0;
            last_port_q <= IDX_W'(NUM_PORTS - 1);
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            last_port_q <= last_port_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic checked against
// a packet-level round-robin model of the merged output stream.
module tb_uart_tx_arbiter;

    localparam int          NP   = 4;
    localparam int          MAXB = 4;
    localparam logic [15:0] HB   = 16'h0100;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [NP*16-1:0] s_tdata = '0;
    logic [NP-1:0] s_tvalid = '0;
    logic [NP-1:0] s_tlast = '0;
    logic [NP-1:0] s_tready;
    logic [15:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [NP-1:0] grant;
    logic          busy;

    logic [NP*16-1:0] np_tdata = '0;
    logic [NP-1:0] np_tvalid = '0;
    logic [NP-1:0] np_tlast = '0;
    logic [NP-1:0] np_tready;
    logic [15:0]   np_m_tdata;
    logic          np_m_tvalid;
    logic          np_m_tready = 1'b0;
    logic [NP-1:0] np_grant;
    logic          np_busy;

    always #5 aclk = ~aclk;

    uart_tx_arbiter #(.NUM_PORTS(NP), .ID_PREFIX(1'b1), .HDR_BASE(HB), .MAX_BEATS(MAXB)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .grant(grant), .busy(busy)
    );

    uart_tx_arbiter #(.NUM_PORTS(NP), .ID_PREFIX(1'b0), .HDR_BASE(HB), .MAX_BEATS(256)) dut_np (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(np_tdata), .s_axis_tvalid(np_tvalid), .s_axis_tlast(np_tlast),
        .s_axis_tready(np_tready),
        .m_axis_tdata(np_m_tdata), .m_axis_tvalid(np_m_tvalid), .m_axis_tready(np_m_tready),
        .grant(np_grant), .busy(np_busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Each source beat: {tlast, tdata}
    logic [16:0] src_q [NP][$];
    logic [16:0] cp_q  [NP][$];
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    int          model_last = NP - 1;
    logic        stall_prev = 1'b0;
    logic [15:0] data_prev = '0;
    logic [NP-1:0] grant_prev = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic clear_queues();
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
        np_tvalid = '0; np_tlast = '0; np_tdata = '0; np_m_tready = 1'b0;
        clear_queues();
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        model_last = NP - 1;
        stall_prev = 1'b0;
        grant_prev = '0;
    endtask

    task automatic add_packet(input int port, input int len, input logic [15:0] base, input bit rnd);
        for (int b = 0; b < len; b++) begin
            logic [15:0] d;
            d = rnd ? 16'($urandom) : base + 16'(b);
            src_q[port].push_back({(b == len - 1), d});
        end
    endtask

    // Packet-level model: every port holding beats is requesting; grants rotate from the last
    // owner, each grant carries an optional header and up to MAXB beats of the current packet.
    task automatic build_expected(input bit prefix, input int maxb);
        int sel;
        int n;
        bit found;
        bit done;
        logic [16:0] b;
        for (int p = 0; p < NP; p++) cp_q[p] = src_q[p];
        forever begin
            found = 1'b0;
            sel = 0;
            for (int off = 1; off <= NP; off++) begin
                int c;
                c = (model_last + off) % NP;
                if (!found && cp_q[c].size() > 0) begin
                    found = 1'b1;
                    sel = c;
                end
            end
            if (!found) break;
            if (prefix) exp_q.push_back(HB | 16'(sel));
            n = 0;
            done = 1'b0;
            while (!done) begin
                b = cp_q[sel].pop_front();
                exp_q.push_back(b[15:0]);
                n++;
                done = b[16] || (n == maxb) || (cp_q[sel].size() == 0);
            end
            model_last = sel;
        end
    endtask

    function automatic bit any_pending();
        bit r;
        r = 1'b0;
        for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) r = 1'b1;
        return r;
    endfunction

    task automatic cycle(input bit rand_rdy);
        logic [NP-1:0] pop;
        @(negedge aclk);
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0) begin
                s_tvalid[p] = 1'b1;
                s_tdata[16*p +: 16] = src_q[p][0][15:0];
                s_tlast[p] = src_q[p][0][16];
            end else begin
                s_tvalid[p] = 1'b0;
                s_tdata[16*p +: 16] = 16'($urandom);
                s_tlast[p] = 1'($urandom_range(0, 1));
            end
        end
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (stall_prev) begin
            check("hold_valid", 32'(m_tvalid), 32'd1);
            check("hold_data", 32'(m_tdata), 32'(data_prev));
        end
        if (grant_prev != '0 && grant != '0) check("no_back_to_back", 32'(grant), 32'(grant_prev));
        if (grant != '0) check("grant_onehot", $countones(grant), 32'd1);
        if (m_tvalid && m_tready) obs_q.push_back(m_tdata);
        pop = s_tvalid & s_tready;
        stall_prev = m_tvalid && !m_tready;
        data_prev = m_tdata;
        grant_prev = grant;
        @(posedge aclk);
        for (int p = 0; p < NP; p++) if (pop[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        #1;
    endtask

    task automatic run_traffic(input int budget, input bit rand_rdy);
        int cnt;
        cnt = 0;
        while ((any_pending() || busy) && cnt < budget) begin
            cycle(rand_rdy);
            cnt++;
        end
        check("traffic_within_budget", 32'(cnt < budget), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int cnt;
        // Reset state
        do_reset();
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tdata", 32'(m_tdata), 32'd0);

        // Port 2 only, three beats
        add_packet(2, 3, 16'h0041, 1'b0);
        exp_q = '{16'h0102, 16'h0041, 16'h0042, 16'h0043};
        model_last = 2;
        run_traffic(200, 1'b0);
        compare_stream("port2_pkt");
        check("port2_busy_after", 32'(busy), 32'd0);
        check("port2_grant_after", 32'(grant), 32'd0);

        // All four ports, single-beat packets: headers rotate 0,1,2,3,0
        do_reset();
        for (int p = 0; p < NP; p++) begin
            add_packet(p, 1, 16'h0A00 + 16'(p * 16), 1'b0);
            add_packet(p, 1, 16'h0B00 + 16'(p * 16), 1'b0);
        end
        build_expected(1'b1, MAXB);
        run_traffic(300, 1'b0);
        if (obs_q.size() >= 10) begin
            check("rr_hdr0", 32'(obs_q[0]), 32'h0100);
            check("rr_hdr1", 32'(obs_q[2]), 32'h0101);
            check("rr_hdr2", 32'(obs_q[4]), 32'h0102);
            check("rr_hdr3", 32'(obs_q[6]), 32'h0103);
            check("rr_hdr4", 32'(obs_q[8]), 32'h0100);
        end
        compare_stream("rr_stream");

        // Forced release after MAXB beats, tail re-arbitrates with a fresh header
        do_reset();
        add_packet(1, 6, 16'h0011, 1'b0);
        exp_q = '{16'h0101, 16'h0011, 16'h0012, 16'h0013, 16'h0014,
                  16'h0101, 16'h0015, 16'h0016};
        model_last = 1;
        run_traffic(300, 1'b0);
        compare_stream("forced_release");

        // Backpressure during header and data
        add_packet(2, 3, 16'h0051, 1'b0);
        exp_q = '{16'h0102, 16'h0051, 16'h0052, 16'h0053};
        model_last = 2;
        run_traffic(400, 1'b1);
        compare_stream("backpressure");

        // Reset during beat 2 of a 5-beat packet on port 3
        do_reset();
        add_packet(3, 5, 16'h0031, 1'b0);
        cnt = 0;
        while (obs_q.size() < 2 && cnt < 50) begin
            cycle(1'b0);
            cnt++;
        end
        check("rst_mid_reached", 32'(obs_q.size()), 32'd2);
        @(negedge aclk);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        check("rst_mid_grant", 32'(grant), 32'd0);
        check("rst_mid_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        clear_queues();
        s_tvalid = 4'b1001;
        s_tlast = 4'b1001;
        @(posedge aclk);
        #1;
        check("rst_mid_port0_wins", 32'(grant), 32'b0001);

        // No header variant: data visible one cycle after the request
        do_reset();
        np_tdata[15:0] = 16'h00AA;
        np_tlast = 4'b0001;
        np_tvalid = 4'b0001;
        np_m_tready = 1'b1;
        @(posedge aclk);
        #1;
        check("nohdr_tvalid", 32'(np_m_tvalid), 32'd1);
        check("nohdr_tdata", 32'(np_m_tdata), 32'h00AA);
        check("nohdr_grant", 32'(np_grant), 32'b0001);
        @(posedge aclk);
        #1;
        np_tvalid = '0;
        check("nohdr_busy_after", 32'(np_busy), 32'd0);

        // Randomized packets on random ports with random backpressure
        do_reset();
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < NP; p++) begin
                int npk;
                npk = $urandom_range(0, 2);
                for (int k = 0; k < npk; k++) add_packet(p, $urandom_range(1, 7), 16'h0, 1'b1);
            end
            build_expected(1'b1, MAXB);
            run_traffic(3000, 1'b1);
            compare_stream($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
